// File: rtl/bsr_pkg.sv
// Shared types for the boundary-scan chain: operating modes and the
// decoded per-cycle strobe operation.
package bsr_pkg;

  typedef enum logic [1:0] {
    BSR_NORMAL = 2'd0,
    BSR_EXTEST = 2'd1,
    BSR_SAMPLE = 2'd2,
    BSR_CLAMP  = 2'd3
  } bsr_mode_t;

  // One operation per cycle; capture outranks shift, which outranks update.
  typedef enum logic [1:0] {
    BSR_OP_NONE    = 2'd0,
    BSR_OP_CAPTURE = 2'd1,
    BSR_OP_SHIFT   = 2'd2,
    BSR_OP_UPDATE  = 2'd3
  } bsr_op_t;

  function automatic bsr_op_t bsr_decode_op(input logic cap, input logic shift, input logic upd);
    if (cap)        return BSR_OP_CAPTURE;
    else if (shift) return BSR_OP_SHIFT;
    else if (upd)   return BSR_OP_UPDATE;
    else            return BSR_OP_NONE;
  endfunction

  function automatic logic bsr_strobe_conflict(input logic cap, input logic shift, input logic upd);
    return (cap & shift) | (cap & upd) | (shift & upd);
  endfunction

endpackage

// File: rtl/bsr_cell_sync.sv
// One boundary-scan channel: WIDTH shift stages, a 1-bit bypass flop,
// the update register and the latched bypass bit.
module bsr_cell_sync
  import bsr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  bsr_op_t          op,
  input  bsr_mode_t        mode,
  input  logic             bypass_req,
  input  logic             si,
  output logic             so,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic             byp_q, byp_d;
  logic             bypass_q, bypass_d;

  always_comb begin
    stage_d  = stage_q;
    upd_d    = upd_q;
    byp_d    = byp_q;
    bypass_d = bypass_q;
    case (op)
      BSR_OP_CAPTURE: begin
        if (mode != BSR_CLAMP) begin
          if (bypass_q) byp_d   = 1'b0;
          else          stage_d = par_in;
        end
      end
      BSR_OP_SHIFT: begin
        if (bypass_q) byp_d   = si;
        else          stage_d = {si, stage_q[WIDTH-1:1]};
      end
      BSR_OP_UPDATE: begin
        // Active-ness is judged by the mask in force before this edge.
        if (!bypass_q) upd_d = stage_q;
        bypass_d = bypass_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q  <= '0;
      upd_q    <= '0;
      byp_q    <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      upd_q    <= upd_d;
      byp_q    <= byp_d;
      bypass_q <= bypass_d;
    end
  end

  assign so = bypass_q ? byp_q : stage_q[0];

  always_comb begin
    par_out = par_in;
    if (!bypass_q && (mode == BSR_EXTEST || mode == BSR_CLAMP)) par_out = upd_q;
  end

endmodule

// File: rtl/bsr_chain_sync.sv
// Boundary-scan chain of NUM_CH channels with per-channel bypass,
// registered chain-length readback and a sticky strobe-conflict flag.
module bsr_chain_sync
  import bsr_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int WIDTH  = 32,
  parameter int LEN_W  = $clog2(NUM_CH*WIDTH+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic [1:0]              mode,
  input  logic [NUM_CH-1:0]       ch_bypass,
  input  logic [NUM_CH*WIDTH-1:0] parallel_in,
  output logic [NUM_CH*WIDTH-1:0] parallel_out,
  output logic [LEN_W-1:0]        chain_len,
  output logic                    protocol_err
);

  bsr_op_t     op;
  bsr_mode_t   mode_e;
  logic [NUM_CH:0] ser;
  logic [LEN_W-1:0] len_q, len_d, new_len;
  logic        err_q, err_d;

  assign op     = bsr_decode_op(capture_dr, shift_dr, update_dr);
  assign mode_e = bsr_mode_t'(mode);
  assign ser[0] = tdi;
  assign tdo    = ser[NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cell
      bsr_cell_sync #(.WIDTH(WIDTH)) u_cell (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mode       (mode_e),
        .bypass_req (ch_bypass[gi]),
        .si         (ser[gi]),
        .so         (ser[gi+1]),
        .par_in     (parallel_in[gi*WIDTH +: WIDTH]),
        .par_out    (parallel_out[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Length follows the mask being latched on this same update edge.
  always_comb begin
    new_len = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      new_len = new_len + (ch_bypass[i] ? LEN_W'(1) : LEN_W'(WIDTH));
    end
  end

  always_comb begin
    len_d = len_q;
    err_d = err_q | bsr_strobe_conflict(capture_dr, shift_dr, update_dr);
    if (op == BSR_OP_UPDATE) len_d = new_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q <= LEN_W'(NUM_CH*WIDTH);
      err_q <= 1'b0;
    end else begin
      len_q <= len_d;
      err_q <= err_d;
    end
  end

  assign chain_len    = len_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_bsr_chain_sync.sv
// Scoreboard bench for bsr_chain_sync with two 8-bit channels: expected
// tdo bits are queued when a capture/shift-in is issued and popped per shift.
module tb_bsr_chain_sync;
  import bsr_pkg::*;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 8;
  localparam int LEN_W  = $clog2(NUM_CH*WIDTH+1);

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic                    tdi = 1'b0;
  logic                    tdo;
  logic [1:0]              mode = BSR_EXTEST;
  logic [NUM_CH-1:0]       ch_bypass = '0;
  logic [NUM_CH*WIDTH-1:0] parallel_in = 16'h3CA5;
  logic [NUM_CH*WIDTH-1:0] parallel_out;
  logic [LEN_W-1:0]        chain_len;
  logic                    protocol_err;

  int   n_total = 0;
  int   n_pass  = 0;
  logic exp_q[$];

  bsr_chain_sync #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .capture_dr   (capture_dr),
    .shift_dr     (shift_dr),
    .update_dr    (update_dr),
    .tdi          (tdi),
    .tdo          (tdo),
    .mode         (mode),
    .ch_bypass    (ch_bypass),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out),
    .chain_len    (chain_len),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic strobe(input logic c, input logic s, input logic u);
    capture_dr = c; shift_dr = s; update_dr = u;
    @(posedge clk); #1;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Queue n bits in the order they appear in the literal, leftmost first.
  task automatic push_seq(input logic [31:0] seq, input int n);
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(seq[k]);
  endtask

  // in_vec bit k is driven on tdi during the k-th shift.
  task automatic shift_n(input int n, input logic [31:0] in_vec, input string tag);
    logic e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s_sb_empty[%0d]", tag, k), 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", tag, k), {31'b0, tdo}, {31'b0, e});
      end
      tdi = in_vec[k];
      strobe(1'b0, 1'b1, 1'b0);
    end
    tdi = 1'b0;
  endtask

  task automatic finish_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_tdo", {31'b0, tdo}, 32'd0);
    check("rst_len", 32'(chain_len), 32'd16);
    check("rst_err", {31'b0, protocol_err}, 32'd0);
    check("rst_pout", 32'(parallel_out), 32'd0);
    finish_reset();

    // Scenario 1: SAMPLE capture and full scan-out.
    $display("scenario 1: sample capture 0x3C/0xA5");
    mode = BSR_SAMPLE;
    #1 check("s1_pout", 32'(parallel_out), 32'h3CA5);
    strobe(1'b1, 1'b0, 1'b0);
    push_seq(32'b0011110010100101, 16);
    shift_n(16, 32'd0, "s1_tdo");
    check("s1_len", 32'(chain_len), 32'd16);

    // Scenario 2: EXTEST shift-in and update.
    $display("scenario 2: extest ch0=0x5A ch1=0xC3");
    mode = BSR_EXTEST;
    push_seq(32'd0, 16);
    shift_n(16, {16'h0, 8'h5A, 8'hC3}, "s2_tdo");
    strobe(1'b0, 1'b0, 1'b1);
    check("s2_pout", 32'(parallel_out), 32'hC35A);
    for (int k = 0; k < 3; k++) begin
      parallel_in = 16'($urandom);
      #1 check($sformatf("s2_pout_hold[%0d]", k), 32'(parallel_out), 32'hC35A);
    end
    mode = BSR_NORMAL;
    #1 check("s2_normal", 32'(parallel_out), 32'(parallel_in));
    check("s2_len", 32'(chain_len), 32'd16);

    // Scenario 3: bypass channel 0.
    $display("scenario 3: bypass ch0");
    ch_bypass = 2'b01;
    strobe(1'b0, 1'b0, 1'b1);
    check("s3_len", 32'(chain_len), 32'd9);
    parallel_in = 16'h8177;
    mode = BSR_EXTEST;
    #1 check("s3_pout_byp", 32'(parallel_out), 32'hC377);
    mode = BSR_SAMPLE;
    strobe(1'b1, 1'b0, 1'b0);
    push_seq(32'b100000010, 9);
    shift_n(9, 32'd0, "s3_tdo");
    ch_bypass = 2'b11;
    idle(3);
    check("s3_len_noupd", 32'(chain_len), 32'd9);
    ch_bypass = 2'b00;
    strobe(1'b0, 1'b0, 1'b1);
    check("s3_len_restore", 32'(chain_len), 32'd16);

    // Scenario 4: strobe conflict.
    $display("scenario 4: capture+shift conflict");
    parallel_in = 16'h0FF0;
    check("s4_err_pre", {31'b0, protocol_err}, 32'd0);
    strobe(1'b1, 1'b1, 1'b0);
    check("s4_err_set", {31'b0, protocol_err}, 32'd1);
    push_seq(32'b1111000000001111, 16);
    shift_n(16, 32'd0, "s4_tdo");
    idle(10);
    check("s4_err_sticky", {31'b0, protocol_err}, 32'd1);
    reset = 1'b1;
    #1 check("s4_err_clr", {31'b0, protocol_err}, 32'd0);
    finish_reset();

    // Scenario 5: reset in the middle of a shift.
    $display("scenario 5: reset mid-shift");
    ch_bypass = 2'b10;
    strobe(1'b0, 1'b0, 1'b1);
    check("s5_len_byp", 32'(chain_len), 32'd9);
    ch_bypass = 2'b00;
    parallel_in = 16'h3CA5;
    strobe(1'b1, 1'b0, 1'b0);
    push_seq(32'b010100101, 9);
    shift_n(6, 32'd0, "s5_tdo");
    check("s5_tdo_pre", {31'b0, tdo}, 32'd1);
    mode = BSR_EXTEST;
    reset = 1'b1;
    #1;
    check("s5_rst_tdo", {31'b0, tdo}, 32'd0);
    check("s5_rst_len", 32'(chain_len), 32'd16);
    check("s5_rst_err", {31'b0, protocol_err}, 32'd0);
    check("s5_rst_pout", 32'(parallel_out), 32'd0);
    finish_reset();
    mode = BSR_SAMPLE;
    strobe(1'b1, 1'b0, 1'b0);
    push_seq(32'b0011110010100101, 16);
    shift_n(16, 32'd0, "s5_tdo_redo");

    // Scenario 6: CLAMP ignores capture.
    $display("scenario 6: clamp 0x22/0x11");
    mode = BSR_EXTEST;
    push_seq(32'd0, 16);
    shift_n(16, {16'h0, 8'h11, 8'h22}, "s6_tdo_in");
    strobe(1'b0, 1'b0, 1'b1);
    mode = BSR_CLAMP;
    #1 check("s6_pout", 32'(parallel_out), 32'h2211);
    parallel_in = 16'hEEFF;
    strobe(1'b1, 1'b0, 1'b0);
    check("s6_pout_cap", 32'(parallel_out), 32'h2211);
    push_seq(32'b0100010010001000, 16);
    shift_n(16, 32'd0, "s6_tdo");
    check("s6_pout_end", 32'(parallel_out), 32'h2211);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bsr_chain_sync.md
Name: bsr_chain_sync

Overview:
Parametrised boundary-scan chain of NUM_CH channels, each WIDTH bits wide, clocked entirely in one clock domain by single-cycle capture/shift/update strobes from the TAP controller. It generalises the per-signal boundary-scan registers around the RISC-V core by adding:
- multi-mode operation (NORMAL/EXTEST/SAMPLE/CLAMP);
- per-channel bypass, so the chain shortens to 1 bit per bypassed channel;
- a registered chain-length readback;
- a sticky protocol-error flag.
It sits between the jtag test logic and core/memory boundary nets.

Parameters:
NUM_CH, 6, number of boundary channels in the chain
WIDTH, 32, bits per channel (uniform)
LEN_W, $clog2(NUM_CH*WIDTH+1), width of chain_len

Ports:
clk  input  1  system/debug clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
capture_dr  input  1  one-cycle strobe: load parallel_in into shift stages
shift_dr  input  1  one-cycle strobe: shift chain one bit toward tdo
update_dr  input  1  one-cycle strobe: copy shift stages to update regs; latch bypass mask
tdi  input  1  serial in, enters channel 0
tdo  output  1  serial out, last active stage of channel NUM_CH-1
mode  input  2  0 NORMAL, 1 EXTEST, 2 SAMPLE, 3 CLAMP
ch_bypass  input  NUM_CH  requested bypass mask, bit i = channel i; takes effect on update_dr
parallel_in  input  NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
parallel_out  output  NUM_CH*WIDTH  driven boundary values, same packing
chain_len  output  LEN_W  current active chain length in bits (registered)
protocol_err  output  1  sticky: more than one strobe asserted in the same cycle

Behaviour:
Reset state:
- Shift stages = 0, update regs = 0, bypass mask = 0 (all channels active).
- chain_len = NUM_CH*WIDTH; protocol_err = 0; tdo = 0.

Strobe priority (per cycle): capture_dr > shift_dr > update_dr.
- Lower-priority strobes are ignored that cycle.
- If two or more strobes are asserted together, protocol_err sets on the next edge and holds until reset.

Capture, next edge:
- Active channel i: shift stage = parallel_in[i].
- Bypassed channel: its 1-bit bypass flop = 0.
- Capture is ignored in CLAMP: stages hold.

Shift, next edge:
- tdi -> channel 0 MSB; each stage moves one place toward LSB.
- LSB of channel i feeds the MSB (or bypass flop) of the next channel, i+1.
- Bypassed channels contribute exactly 1 flop; their WIDTH stages hold their value.
- tdo = LSB (or bypass flop) of channel NUM_CH-1, taken directly from the flop, no extra register. LSB-first out.

Update, next edge:
- Update reg of each active channel = its shift stage; bypassed channels' update regs hold.
- Same edge: bypass mask = ch_bypass.
- Same edge: chain_len = sum over i of (mask_i ? 1 : WIDTH), using the newly latched mask.
- A mask change therefore never alters the chain mid-shift. ch_bypass changes without update_dr have no effect.

parallel_out, combinational on mode:
- NORMAL, SAMPLE: parallel_out = parallel_in.
- EXTEST, CLAMP: parallel_out = update regs.
- A bypassed channel always drives parallel_in, in every mode.

Other rules:
- mode may change on any cycle; parallel_out follows in the same cycle. No state is lost.
- Reset mid-shift: all state returns to reset values immediately (async). Partial shift data is discarded.
- Arithmetic: chain_len is sized by LEN_W and computed without overflow for all masks.
- Minimum chain_len is NUM_CH (all bypassed).

Decomposition:
- Package bsr_pkg:
  - typedef enum logic[1:0] bsr_mode_t {BSR_NORMAL, BSR_EXTEST, BSR_SAMPLE, BSR_CLAMP};
  - localparam for the strobe priority encoding.
- Sub-module bsr_cell_sync: one channel. It holds the WIDTH shift stages, the bypass flop, the update reg and the bypass bit, and exposes serial in/out plus parallel in/out.
- The top instantiates NUM_CH cells via generate and computes chain_len.

Test Plan:
- NUM_CH=2, WIDTH=8, mode=SAMPLE, parallel_in ch0=0xA5, ch1=0x3C; capture then 16 shifts -> tdo sequence 0,0,1,1,1,1,0,0, 1,0,1,0,0,1,0,1; chain_len=16.
- mode=EXTEST; shift in 16 bits so that ch0=0x5A, ch1=0xC3; update -> parallel_out={0xC3,0x5A} while parallel_in changes arbitrarily. Switch to NORMAL -> parallel_out=parallel_in the same cycle.
- ch_bypass=2'b01 plus update -> chain_len=9. Capture ch1=0x81; 9 shifts -> tdo = 1,0,0,0,0,0,0,1, then 0 (the bypass flop).
- capture_dr and shift_dr asserted together -> capture only performed, protocol_err=1 next cycle and still 1 after 10 idle cycles; reset clears it.
- Assert reset after 5 of 16 shifts -> all outputs return to reset values immediately. A following capture/shift reproduces the first scenario exactly.
- mode=CLAMP with update regs=0x11/0x22; capture with new parallel_in -> stages unchanged (shift-out returns old data), parallel_out stays {0x22,0x11}.
